// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generation, synchronous imem reads and a DEPTH-entry
// prefetch queue of {pc, instr} pairs, decoupled from decode by valid/ready.
module fetch_queue #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 12,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  input  logic [DATA_W-1:0] ir_m_q,
  output logic [ADDR_W-1:0] ir_m_addr,
  output logic              ir_m_rw,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ir,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic              pending;
  logic [ADDR_W-1:0] pending_pc;
  logic [DATA_W-1:0] ir_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              pop;
  logic              push;
  logic              issue;
  logic [OCC_W-1:0]  occ;
  logic [PTR_W-1:0]  rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_d;
  logic [CNT_W-1:0]  count_d;
  logic [DATA_W-1:0] head_ir_d;
  logic [ADDR_W-1:0] head_pc_d;

  assign ir_m_addr = fetch_pc;
  assign ir_m_rw   = 1'b0;

  // Next queue state; the head outputs are precomputed here so they can be registered.
  always_comb begin
    pop       = out_valid & out_ready;
    push      = pending & ~redirect;
    // Occupancy counts the in-flight read so a slot is always reserved for it.
    occ       = OCC_W'(count) + OCC_W'(pending) - OCC_W'(pop);
    issue     = exec & ~redirect & (occ < OCC_W'(DEPTH));
    rd_ptr_d  = rd_ptr;
    wr_ptr_d  = wr_ptr;
    count_d   = count;
    head_ir_d = '0;
    head_pc_d = '0;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr + PTR_W'(1);
      if (push) wr_ptr_d = wr_ptr + PTR_W'(1);
      count_d = count + CNT_W'(push) - CNT_W'(pop);
    end
    if (count_d != '0) begin
      if (push && (wr_ptr == rd_ptr_d)) begin
        head_ir_d = ir_m_q;
        head_pc_d = pending_pc;
      end else begin
        head_ir_d = ir_mem[rd_ptr_d];
        head_pc_d = pc_mem[rd_ptr_d];
      end
    end
  end

  // Control, pointers and registered head.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_ir     <= '0;
      out_pc     <= '0;
    end else begin
      rd_ptr    <= rd_ptr_d;
      wr_ptr    <= wr_ptr_d;
      count     <= count_d;
      out_valid <= (count_d != '0);
      out_ir    <= head_ir_d;
      out_pc    <= head_pc_d;
      pending   <= issue;
      if (issue) pending_pc <= fetch_pc;
      if (redirect)   fetch_pc <= redirect_pc;
      else if (issue) fetch_pc <= fetch_pc + ADDR_W'(1);
    end
  end

  // Queue storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      ir_mem[wr_ptr] <= ir_m_q;
      pc_mem[wr_ptr] <= pending_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-level reference model checked every cycle, plus directed
// scenarios with hand-computed expectations (second instance covers a wrapping RESET_PC).
module tb_fetch_queue;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          exec = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_ready = 1'b0;

  logic [DW-1:0] ir_m_q;
  logic [AW-1:0] ir_m_addr;
  logic          ir_m_rw;
  logic          out_valid;
  logic [DW-1:0] out_ir;
  logic [AW-1:0] out_pc;

  logic [DW-1:0] w_ir_m_q;
  logic [AW-1:0] w_ir_m_addr;
  logic          w_ir_m_rw;
  logic          w_out_valid;
  logic [DW-1:0] w_out_ir;
  logic [AW-1:0] w_out_pc;

  int n_vec = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  fetch_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(12'h000)) u_dut (
    .clock(clock), .reset(reset), .exec(exec), .ir_m_q(ir_m_q), .ir_m_addr(ir_m_addr),
    .ir_m_rw(ir_m_rw), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc)
  );

  fetch_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(12'hFFE)) u_dut_w (
    .clock(clock), .reset(reset), .exec(exec), .ir_m_q(w_ir_m_q), .ir_m_addr(w_ir_m_addr),
    .ir_m_rw(w_ir_m_rw), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_ir(w_out_ir), .out_pc(w_out_pc)
  );

  // Synchronous instruction memories: mem[a] = 0x100 + a.
  always @(posedge clock) begin
    ir_m_q   <= 16'h100 + DW'(ir_m_addr);
    w_ir_m_q <= 16'h100 + DW'(w_ir_m_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Reference model: fetch PC, one in-flight read, and a queue of buffered PCs.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_pend_pc;
  bit            m_pend;
  logic [AW-1:0] m_q[$];

  always @(posedge clock) begin
    bit m_pop;
    bit m_iss;
    int m_occ;
    if (reset) begin
      m_pc      = 12'h000;
      m_pend    = 1'b0;
      m_pend_pc = '0;
      m_q.delete();
    end else begin
      m_pop = (m_q.size() != 0) && (out_ready === 1'b1);
      m_occ = m_q.size() + int'(m_pend) - int'(m_pop);
      m_iss = (exec === 1'b1) && (redirect !== 1'b1) && (m_occ < int'(DEPTH));
      if (m_pop) void'(m_q.pop_front());
      if (redirect === 1'b1) begin
        m_q.delete();
        m_pend = 1'b0;
        m_pc   = redirect_pc;
      end else begin
        if (m_pend) m_q.push_back(m_pend_pc);
        m_pend = m_iss;
        if (m_iss) begin
          m_pend_pc = m_pc;
          m_pc      = m_pc + 12'd1;
        end
      end
    end
  end

  // Every-cycle comparison of the main instance against the model.
  always @(negedge clock) begin
    logic [AW-1:0] e_pc;
    logic [DW-1:0] e_ir;
    bit            e_v;
    if (chk_en) begin
      e_v  = (m_q.size() != 0);
      e_pc = '0;
      e_ir = '0;
      if (e_v) begin
        e_pc = m_q[0];
        e_ir = 16'h100 + DW'(m_q[0]);
      end
      chk("model_out_valid", 32'(out_valid), 32'(e_v));
      chk("model_out_pc", 32'(out_pc), 32'(e_pc));
      chk("model_out_ir", 32'(out_ir), 32'(e_ir));
      chk("model_ir_m_addr", 32'(ir_m_addr), 32'(m_pc));
      chk("model_ir_m_rw", 32'(ir_m_rw), 0);
    end
  end

  initial begin
    logic [AW-1:0] pe;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pc", 32'(out_pc), 0);
    chk("rst_addr", 32'(ir_m_addr), 0);
    chk("rst_addr_w", 32'(w_ir_m_addr), 'hFFE);

    // Streaming from reset; c0 is this cycle.
    reset = 1'b0; exec = 1'b1; out_ready = 1'b1;
    step();
    chk("s1_c1_valid", 32'(out_valid), 0);
    chk("s1_c1_addr", 32'(ir_m_addr), 1);
    step();
    chk("s1_c2_valid", 32'(out_valid), 1);
    chk("s1_c2_pc", 32'(out_pc), 0);
    chk("s1_c2_ir", 32'(out_ir), 'h100);
    chk("wrap_c2_pc", 32'(w_out_pc), 'hFFE);
    chk("wrap_c2_ir", 32'(w_out_ir), 'h10FE);
    step();
    chk("s1_c3_pc", 32'(out_pc), 1);
    chk("s1_c3_ir", 32'(out_ir), 'h101);
    chk("wrap_c3_pc", 32'(w_out_pc), 'hFFF);
    step();
    chk("s1_c4_pc", 32'(out_pc), 2);
    chk("wrap_c4_pc", 32'(w_out_pc), 'h000);
    chk("wrap_c4_ir", 32'(w_out_ir), 'h100);
    step();
    chk("s1_c5_pc", 32'(out_pc), 3);
    chk("wrap_c5_pc", 32'(w_out_pc), 'h001);

    // Redirect in cycle r with a read in flight and a pop in the same cycle.
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 12'h040;
    step();
    redirect = 1'b0;
    chk("rd_r1_valid", 32'(out_valid), 0);
    step();
    chk("rd_r2_valid", 32'(out_valid), 0);
    step();
    chk("rd_r3_valid", 32'(out_valid), 1);
    chk("rd_r3_pc", 32'(out_pc), 'h040);
    chk("rd_r3_ir", 32'(out_ir), 'h140);
    step();
    chk("rd_r4_pc", 32'(out_pc), 'h041);

    // exec=0 mid-stream: in-flight read lands, queue drains, then resume.
    repeat (3) step();
    pe = out_pc;
    exec = 1'b0;
    step();
    chk("ex_e1_valid", 32'(out_valid), 1);
    chk("ex_e1_pc", 32'(out_pc), 32'(pe + 12'd1));
    step();
    chk("ex_e2_valid", 32'(out_valid), 0);
    chk("ex_e2_addr", 32'(ir_m_addr), 32'(pe + 12'd2));
    exec = 1'b1;
    step();
    chk("ex_e3_valid", 32'(out_valid), 0);
    step();
    chk("ex_e4_valid", 32'(out_valid), 1);
    chk("ex_e4_pc", 32'(out_pc), 32'(pe + 12'd2));

    // Back-pressure from c0: queue fills to DEPTH, then drains in order.
    reset = 1'b1;
    step();
    reset = 1'b0; out_ready = 1'b0;
    repeat (8) step();
    chk("bp_full_valid", 32'(out_valid), 1);
    chk("bp_full_pc", 32'(out_pc), 0);
    chk("bp_full_addr", 32'(ir_m_addr), 4);
    step();
    chk("bp_hold_pc", 32'(out_pc), 0);
    chk("bp_hold_ir", 32'(out_ir), 'h100);
    chk("bp_hold_addr", 32'(ir_m_addr), 4);
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("bp_drain_pc", 32'(out_pc), 32'(i));
    end

    // Reset with a full queue.
    out_ready = 1'b0;
    repeat (6) step();
    chk("rf_full_valid", 32'(out_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rf_valid", 32'(out_valid), 0);
    chk("rf_pc", 32'(out_pc), 0);
    chk("rf_addr", 32'(ir_m_addr), 0);
    out_ready = 1'b1;
    step();
    chk("rf_c1_valid", 32'(out_valid), 0);
    step();
    chk("rf_c2_valid", 32'(out_valid), 1);
    chk("rf_c2_pc", 32'(out_pc), 0);

    // Redirect while exec=0 on a full queue still flushes and moves the PC.
    out_ready = 1'b0;
    repeat (6) step();
    exec = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 12'h200;
    step();
    redirect = 1'b0;
    chk("rx_valid", 32'(out_valid), 0);
    chk("rx_addr", 32'(ir_m_addr), 'h200);
    step();
    chk("rx_idle_valid", 32'(out_valid), 0);
    chk("rx_idle_addr", 32'(ir_m_addr), 'h200);
    exec = 1'b1; out_ready = 1'b1;
    step();
    step();
    chk("rx_resume_valid", 32'(out_valid), 1);
    chk("rx_resume_pc", 32'(out_pc), 'h200);
    chk("rx_resume_ir", 32'(out_ir), 'h300);

    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
